// File: rtl/rob_pkg.sv
// Shared definitions for the reorder buffer: instruction kinds and width defaults.
package rob_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [1:0] {
    KIND_REG    = 2'd0,
    KIND_BRANCH = 2'd1,
    KIND_STORE  = 2'd2,
    KIND_NOP    = 2'd3
  } kind_e;

endpackage

// File: rtl/rob_wb_match.sv
// Priority match of one ROB tag against all writeback ports; the lowest port index wins.
module rob_wb_match #(
  parameter int NUM_WB = 2,
  parameter int IW     = 4,
  parameter int IDXW   = 1
) (
  input  logic [IW-1:0]        tag_i,
  input  logic [NUM_WB-1:0]    wb_valid_i,
  input  logic [NUM_WB*IW-1:0] wb_tag_i,
  output logic                 hit_o,
  output logic [IDXW-1:0]      idx_o
);

  // Scan from the highest port down so the lowest matching index is the last one written.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = NUM_WB - 1; i >= 0; i--) begin
      if (wb_valid_i[i] && (wb_tag_i[i*IW +: IW] == tag_i)) begin
        hit_o = 1'b1;
        idx_o = IDXW'(i);
      end
    end
  end

endmodule

// File: rtl/rob_multi_wb.sv
// Reorder buffer: circular queue with multi-port writeback, operand bypass,
// in-order commit and single-cycle flush on branch mispredict.
module rob_multi_wb
  import rob_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int NUM_WB = 2,
  parameter int XLEN   = XLEN_DEFAULT,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   rdy,
  input  logic                   disp_valid,
  output logic                   disp_ready,
  input  logic [4:0]             disp_rd,
  input  logic [1:0]             disp_kind,
  input  logic                   disp_pred_taken,
  input  logic [XLEN-1:0]        disp_alt_pc,
  output logic [IW-1:0]          disp_tag,
  input  logic [IW-1:0]          q1_tag,
  input  logic [IW-1:0]          q2_tag,
  output logic                   q1_ready,
  output logic                   q2_ready,
  output logic [XLEN-1:0]        q1_val,
  output logic [XLEN-1:0]        q2_val,
  input  logic [NUM_WB-1:0]      wb_valid,
  input  logic [NUM_WB*IW-1:0]   wb_tag,
  input  logic [NUM_WB*XLEN-1:0] wb_val,
  input  logic [NUM_WB-1:0]      wb_taken,
  output logic                   commit_valid,
  output logic [IW-1:0]          commit_tag,
  output logic [4:0]             commit_rd,
  output logic [XLEN-1:0]        commit_val,
  output logic                   commit_store,
  output logic                   flush,
  output logic [XLEN-1:0]        flush_pc,
  output logic [IW:0]            count,
  output logic                   empty,
  output logic                   full
);

  localparam int IDXW = (NUM_WB > 1) ? $clog2(NUM_WB) : 1;

  logic [DEPTH-1:0] busy_q, busy_d, ready_q, ready_d, taken_q, pred_q;
  logic [XLEN-1:0]  val_q [DEPTH];
  logic [XLEN-1:0]  alt_q [DEPTH];
  logic [4:0]       rd_q  [DEPTH];
  kind_e            kind_q [DEPTH];
  logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [IW:0]      count_q, count_d;
  logic             flush_q, flush_d;
  logic [XLEN-1:0]  flush_pc_q, flush_pc_d;

  logic [DEPTH-1:0] ent_hit_s;
  logic [IDXW-1:0]  ent_idx_s [DEPTH];
  logic             q1_hit_s, q2_hit_s;
  logic [IDXW-1:0]  q1_idx_s, q2_idx_s;
  logic             disp_fire_s, mispredict_s;

  function automatic logic [XLEN-1:0] wb_val_at(input logic [IDXW-1:0] idx);
    return wb_val[idx*XLEN +: XLEN];
  endfunction

  for (genvar e = 0; e < DEPTH; e++) begin : g_ent
    rob_wb_match #(.NUM_WB(NUM_WB), .IW(IW), .IDXW(IDXW)) u_match (
      .tag_i(IW'(e)), .wb_valid_i(wb_valid), .wb_tag_i(wb_tag),
      .hit_o(ent_hit_s[e]), .idx_o(ent_idx_s[e])
    );
  end

  rob_wb_match #(.NUM_WB(NUM_WB), .IW(IW), .IDXW(IDXW)) u_q1 (
    .tag_i(q1_tag), .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .hit_o(q1_hit_s), .idx_o(q1_idx_s)
  );
  rob_wb_match #(.NUM_WB(NUM_WB), .IW(IW), .IDXW(IDXW)) u_q2 (
    .tag_i(q2_tag), .wb_valid_i(wb_valid), .wb_tag_i(wb_tag), .hit_o(q2_hit_s), .idx_o(q2_idx_s)
  );

  assign full         = (count_q == (IW+1)'(DEPTH));
  assign empty        = (count_q == '0);
  assign count        = count_q;
  assign disp_ready   = !full && !flush_q;
  assign disp_tag     = tail_q;
  assign flush        = flush_q;
  assign flush_pc     = flush_pc_q;

  // Commit looks only at registered state; a same-cycle writeback cannot reach it.
  assign commit_valid = rdy && !empty && ready_q[head_q];
  assign commit_tag   = head_q;
  assign commit_rd    = (kind_q[head_q] == KIND_REG) ? rd_q[head_q] : 5'd0;
  assign commit_val   = val_q[head_q];
  assign commit_store = commit_valid && (kind_q[head_q] == KIND_STORE);
  assign mispredict_s = commit_valid && (kind_q[head_q] == KIND_BRANCH) &&
                        (taken_q[head_q] != pred_q[head_q]);
  assign disp_fire_s  = rdy && disp_valid && disp_ready && !mispredict_s;

  assign q1_ready = ready_q[q1_tag] || q1_hit_s;
  assign q2_ready = ready_q[q2_tag] || q2_hit_s;
  assign q1_val   = ready_q[q1_tag] ? val_q[q1_tag] : (q1_hit_s ? wb_val_at(q1_idx_s) : '0);
  assign q2_val   = ready_q[q2_tag] ? val_q[q2_tag] : (q2_hit_s ? wb_val_at(q2_idx_s) : '0);

  // Next-state for pointers, occupancy, entry status and flush.
  always_comb begin
    busy_d     = busy_q;
    ready_d    = ready_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush_d    = flush_q;
    flush_pc_d = flush_pc_q;
    if (rdy) begin
      flush_d = mispredict_s;
      if (mispredict_s) begin
        busy_d     = '0;
        ready_d    = '0;
        head_d     = '0;
        tail_d     = '0;
        count_d    = '0;
        flush_pc_d = alt_q[head_q];
      end else begin
        ready_d = ready_q | (ent_hit_s & busy_q);
        if (commit_valid) begin
          busy_d[head_q]  = 1'b0;
          ready_d[head_q] = 1'b0;
          head_d          = head_q + 1'b1;
        end
        if (disp_fire_s) begin
          busy_d[tail_q]  = 1'b1;
          ready_d[tail_q] = 1'b0;
          tail_d          = tail_q + 1'b1;
        end
        count_d = count_q + (IW+1)'(disp_fire_s) - (IW+1)'(commit_valid);
      end
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= '0;
      ready_q    <= '0;
      head_q     <= '0;
      tail_q     <= '0;
      count_q    <= '0;
      flush_q    <= 1'b0;
      flush_pc_q <= '0;
    end else begin
      busy_q     <= busy_d;
      ready_q    <= ready_d;
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      flush_q    <= flush_d;
      flush_pc_q <= flush_pc_d;
    end
  end

  // Entry payload; qualified by busy/ready so it needs no reset.
  always_ff @(posedge clk) begin
    if (rdy) begin
      for (int e = 0; e < DEPTH; e++) begin
        if (ent_hit_s[e] && busy_q[e]) begin
          val_q[e]   <= wb_val_at(ent_idx_s[e]);
          taken_q[e] <= wb_taken[ent_idx_s[e]];
        end
      end
      if (disp_fire_s) begin
        rd_q[tail_q]   <= disp_rd;
        kind_q[tail_q] <= kind_e'(disp_kind);
        pred_q[tail_q] <= disp_pred_taken;
        alt_q[tail_q]  <= disp_alt_pc;
      end
    end
  end

endmodule

// File: tb/tb_rob_multi_wb.sv
// Self-checking bench for rob_multi_wb: directed table, corner-case sequences and
// randomized traffic against a queue-based reference model.
module tb_rob_multi_wb;

  logic        clk, rst, rdy;
  logic        disp_valid, disp_ready, disp_pred_taken;
  logic [4:0]  disp_rd;
  logic [1:0]  disp_kind;
  logic [31:0] disp_alt_pc;
  logic [3:0]  disp_tag, q1_tag, q2_tag, commit_tag;
  logic        q1_ready, q2_ready;
  logic [31:0] q1_val, q2_val, commit_val, flush_pc;
  logic [1:0]  wb_valid, wb_taken;
  logic [7:0]  wb_tag;
  logic [63:0] wb_val;
  logic        commit_valid, commit_store, flush, empty, full;
  logic [4:0]  commit_rd, count;

  int checks = 0;
  int failures = 0;

  rob_multi_wb #(.DEPTH(16), .NUM_WB(2), .XLEN(32)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_rd(disp_rd),
    .disp_kind(disp_kind), .disp_pred_taken(disp_pred_taken), .disp_alt_pc(disp_alt_pc),
    .disp_tag(disp_tag), .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready),
    .q2_ready(q2_ready), .q1_val(q1_val), .q2_val(q2_val), .wb_valid(wb_valid),
    .wb_tag(wb_tag), .wb_val(wb_val), .wb_taken(wb_taken), .commit_valid(commit_valid),
    .commit_tag(commit_tag), .commit_rd(commit_rd), .commit_val(commit_val),
    .commit_store(commit_store), .flush(flush), .flush_pc(flush_pc), .count(count),
    .empty(empty), .full(full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the ROB as an ordered list of live entries.
  typedef struct {
    bit [3:0]  tag;
    bit [4:0]  rd;
    bit [1:0]  kind;
    bit        pred;
    bit [31:0] alt;
    bit        ready;
    bit [31:0] val;
    bit        taken;
  } ment_t;

  ment_t     mq[$];
  bit [3:0]  m_tail;
  bit        m_flush;
  bit [31:0] m_flush_pc;

  typedef struct {
    bit dv; bit [4:0] rd;
    bit w0v; bit [3:0] w0t; bit [31:0] w0d;
    bit w1v; bit [3:0] w1t; bit [31:0] w1d;
    bit [3:0] q1t;
    bit [4:0] ecnt; bit ecv; bit [3:0] ectag; bit [31:0] ecval;
    bit eq1r; bit [31:0] eq1v; bit [3:0] etag;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mkv(bit dv, bit [4:0] rd, bit w0v, bit [3:0] w0t, bit [31:0] w0d,
                               bit w1v, bit [3:0] w1t, bit [31:0] w1d, bit [3:0] q1t,
                               bit [4:0] ecnt, bit ecv, bit [3:0] ectag, bit [31:0] ecval,
                               bit eq1r, bit [31:0] eq1v, bit [3:0] etag);
    vec_t v;
    v.dv = dv; v.rd = rd; v.w0v = w0v; v.w0t = w0t; v.w0d = w0d;
    v.w1v = w1v; v.w1t = w1t; v.w1d = w1d; v.q1t = q1t; v.ecnt = ecnt;
    v.ecv = ecv; v.ectag = ectag; v.ecval = ecval; v.eq1r = eq1r; v.eq1v = eq1v; v.etag = etag;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_tail = 4'd0;
    m_flush = 1'b0;
    m_flush_pc = 32'd0;
  endtask

  task automatic idle();
    rdy = 1'b1; disp_valid = 1'b0; wb_valid = 2'b00; wb_taken = 2'b00;
  endtask

  task automatic set_wb(input int p, input bit [3:0] t, input bit [31:0] v, input bit tk);
    wb_valid[p] = 1'b1;
    wb_tag[p*4 +: 4] = t;
    wb_val[p*32 +: 32] = v;
    wb_taken[p] = tk;
  endtask

  task automatic disp(input bit [1:0] k, input bit [4:0] rd, input bit pred, input bit [31:0] alt);
    disp_valid = 1'b1; disp_kind = k; disp_rd = rd; disp_pred_taken = pred; disp_alt_pc = alt;
  endtask

  function automatic void mlook(input bit [3:0] t, output bit r, output bit [31:0] v);
    r = 1'b0;
    v = 32'd0;
    foreach (mq[k]) if (mq[k].tag == t && mq[k].ready) begin r = 1'b1; v = mq[k].val; end
    if (!r) begin
      for (int p = 1; p >= 0; p--) begin
        if (wb_valid[p] && wb_tag[p*4 +: 4] == t) begin r = 1'b1; v = wb_val[p*32 +: 32]; end
      end
    end
  endfunction

  // Called at a falling edge with inputs set: compare against model, advance model, wait a cycle.
  task automatic step();
    int sz;
    bit efull, ecv, mis, acc, r;
    bit [31:0] v, alt;
    ment_t ne;
    #1;
    sz = mq.size();
    efull = (sz == 16);
    chk("m_count", count, sz);
    chk("m_empty", empty, sz == 0);
    chk("m_full", full, efull);
    chk("m_count_le_depth", count <= 5'd16, 1'b1);
    chk("m_disp_ready", disp_ready, !efull && !m_flush);
    chk("m_disp_tag", disp_tag, m_tail);
    chk("m_flush", flush, m_flush);
    chk("m_flush_pc", flush_pc, m_flush_pc);
    ecv = rdy && (sz > 0) && mq[0].ready;
    chk("m_commit_valid", commit_valid, ecv);
    chk("m_commit_store", commit_store, ecv && mq[0].kind == 2'd2);
    if (ecv) begin
      chk("m_commit_tag", commit_tag, mq[0].tag);
      chk("m_commit_rd", commit_rd, (mq[0].kind == 2'd0) ? mq[0].rd : 5'd0);
      chk("m_commit_val", commit_val, mq[0].val);
    end
    mlook(q1_tag, r, v);
    chk("m_q1_ready", q1_ready, r);
    chk("m_q1_val", q1_val, v);
    mlook(q2_tag, r, v);
    chk("m_q2_ready", q2_ready, r);
    chk("m_q2_val", q2_val, v);
    if (rdy) begin
      mis = ecv && mq[0].kind == 2'd1 && mq[0].taken != mq[0].pred;
      acc = disp_valid && !efull && !m_flush && !mis;
      alt = (sz > 0) ? mq[0].alt : 32'd0;
      for (int k = 0; k < mq.size(); k++) begin
        for (int p = 0; p < 2; p++) begin
          if (wb_valid[p] && wb_tag[p*4 +: 4] == mq[k].tag) begin
            mq[k].ready = 1'b1; mq[k].val = wb_val[p*32 +: 32]; mq[k].taken = wb_taken[p];
            break;
          end
        end
      end
      if (ecv) void'(mq.pop_front());
      if (acc) begin
        ne.tag = m_tail; ne.rd = disp_rd; ne.kind = disp_kind; ne.pred = disp_pred_taken;
        ne.alt = disp_alt_pc; ne.ready = 1'b0; ne.val = 32'd0; ne.taken = 1'b0;
        mq.push_back(ne);
        m_tail = m_tail + 4'd1;
      end
      if (mis) begin
        mq.delete();
        m_tail = 4'd0;
        m_flush_pc = alt;
      end
      m_flush = mis;
    end
    @(negedge clk);
  endtask

  initial begin
    bit [3:0] t;
    rst = 1'b1; idle();
    disp_rd = 5'd0; disp_kind = 2'd0; disp_pred_taken = 1'b0; disp_alt_pc = 32'd0;
    q1_tag = 4'd0; q2_tag = 4'd0; wb_tag = 8'd0; wb_val = 64'd0;

    for (int i = 0; i < 16; i++)
      tbl[i] = mkv(1'b1, 5'(i + 1), 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0, 4'd0,
                   5'(i), 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 4'(i));
    tbl[16] = mkv(1'b0, 5'd0, 1'b1, 4'd2, 32'h22, 1'b0, 4'd0, 32'd0, 4'd2, 5'd16, 1'b0, 4'd0, 32'd0,   1'b1, 32'h22, 4'd0);
    tbl[17] = mkv(1'b0, 5'd0, 1'b1, 4'd0, 32'h20, 1'b0, 4'd0, 32'd0, 4'd2, 5'd16, 1'b0, 4'd0, 32'd0,   1'b1, 32'h22, 4'd0);
    tbl[18] = mkv(1'b1, 5'd3, 1'b1, 4'd1, 32'h21, 1'b0, 4'd0, 32'd0, 4'd0, 5'd16, 1'b1, 4'd0, 32'h20, 1'b1, 32'h20, 4'd0);
    tbl[19] = mkv(1'b0, 5'd0, 1'b0, 4'd0, 32'd0,  1'b0, 4'd0, 32'd0, 4'd1, 5'd15, 1'b1, 4'd1, 32'h21, 1'b1, 32'h21, 4'd0);
    tbl[20] = mkv(1'b0, 5'd0, 1'b1, 4'd3, 32'hA,  1'b1, 4'd3, 32'hB, 4'd3, 5'd14, 1'b1, 4'd2, 32'h22, 1'b1, 32'hA,  4'd0);
    tbl[21] = mkv(1'b0, 5'd0, 1'b0, 4'd0, 32'd0,  1'b0, 4'd0, 32'd0, 4'd3, 5'd13, 1'b1, 4'd3, 32'hA,  1'b1, 32'hA,  4'd0);
    tbl[22] = mkv(1'b0, 5'd0, 1'b0, 4'd0, 32'd0,  1'b0, 4'd0, 32'd0, 4'd3, 5'd12, 1'b0, 4'd0, 32'd0,   1'b0, 32'd0,  4'd0);

    // Reset state
    #1;
    chk("rst_count", count, 5'd0);
    chk("rst_empty", empty, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_disp_ready", disp_ready, 1'b1);
    chk("rst_commit_valid", commit_valid, 1'b0);
    chk("rst_commit_store", commit_store, 1'b0);
    chk("rst_flush", flush, 1'b0);
    chk("rst_flush_pc", flush_pc, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Fill to full, out-of-order writeback, dual-port same-tag writeback
    foreach (tbl[i]) begin
      idle();
      disp_valid = tbl[i].dv; disp_kind = 2'd0; disp_rd = tbl[i].rd;
      if (tbl[i].w0v) set_wb(0, tbl[i].w0t, tbl[i].w0d, 1'b0);
      if (tbl[i].w1v) set_wb(1, tbl[i].w1t, tbl[i].w1d, 1'b0);
      q1_tag = tbl[i].q1t;
      #1;
      chk("tbl_count", count, tbl[i].ecnt);
      chk("tbl_full", full, tbl[i].ecnt == 5'd16);
      chk("tbl_disp_ready", disp_ready, tbl[i].ecnt != 5'd16);
      chk("tbl_disp_tag", disp_tag, tbl[i].etag);
      chk("tbl_commit_valid", commit_valid, tbl[i].ecv);
      chk("tbl_q1_ready", q1_ready, tbl[i].eq1r);
      chk("tbl_q1_val", q1_val, tbl[i].eq1v);
      if (tbl[i].ecv) begin
        chk("tbl_commit_tag", commit_tag, tbl[i].ectag);
        chk("tbl_commit_val", commit_val, tbl[i].ecval);
      end
      step();
    end

    // Reset with 12 live entries: everything discarded, no commit or flush
    idle();
    rst = 1'b1;
    #1;
    chk("midrst_count", count, 5'd0);
    chk("midrst_empty", empty, 1'b1);
    chk("midrst_commit_valid", commit_valid, 1'b0);
    chk("midrst_flush", flush, 1'b0);
    chk("midrst_disp_ready", disp_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Mispredicted branch at head
    idle(); disp(2'd1, 5'd9, 1'b1, 32'h100); step();
    idle(); disp(2'd0, 5'd4, 1'b0, 32'd0); step();
    idle(); set_wb(0, 4'd0, 32'd0, 1'b0); step();
    idle(); disp(2'd0, 5'd6, 1'b0, 32'd0); #1;
    chk("mp_commit_valid", commit_valid, 1'b1);
    chk("mp_commit_rd", commit_rd, 5'd0);
    chk("mp_flush_before", flush, 1'b0);
    step();
    idle(); disp(2'd0, 5'd6, 1'b0, 32'd0); #1;
    chk("mp_flush", flush, 1'b1);
    chk("mp_flush_pc", flush_pc, 32'h100);
    chk("mp_count", count, 5'd0);
    chk("mp_disp_ready", disp_ready, 1'b0);
    step();
    idle(); disp(2'd0, 5'd5, 1'b0, 32'd0); #1;
    chk("mp_flush_fell", flush, 1'b0);
    chk("mp_disp_ready_again", disp_ready, 1'b1);
    chk("mp_disp_tag", disp_tag, 4'd0);
    step();
    // Correctly predicted branch
    idle(); disp(2'd1, 5'd1, 1'b1, 32'h200); set_wb(1, 4'd0, 32'h55, 1'b0); step();
    idle(); set_wb(0, 4'd1, 32'd0, 1'b1); #1;
    chk("cp_commit_tag0", commit_tag, 4'd0);
    chk("cp_commit_val0", commit_val, 32'h55);
    step();
    idle(); #1;
    chk("cp_commit_valid", commit_valid, 1'b1);
    chk("cp_commit_tag1", commit_tag, 4'd1);
    step();
    idle(); #1;
    chk("cp_no_flush", flush, 1'b0);
    chk("cp_count", count, 5'd0);
    chk("cp_flush_pc_held", flush_pc, 32'h100);
    step();

    // Store commit, then a stalled cycle
    idle(); disp(2'd2, 5'd7, 1'b0, 32'd0); step();
    idle(); disp(2'd0, 5'd8, 1'b0, 32'd0); step();
    idle(); set_wb(0, 4'd2, 32'h77, 1'b0); set_wb(1, 4'd3, 32'h88, 1'b0); step();
    idle(); #1;
    chk("st_commit_store", commit_store, 1'b1);
    chk("st_commit_rd", commit_rd, 5'd0);
    chk("st_commit_tag", commit_tag, 4'd2);
    step();
    idle(); rdy = 1'b0; disp(2'd0, 5'd9, 1'b0, 32'd0); set_wb(0, 4'd3, 32'h99, 1'b0); #1;
    chk("st_stall_commit_valid", commit_valid, 1'b0);
    chk("st_stall_commit_store", commit_store, 1'b0);
    step();
    idle(); #1;
    chk("st_after_stall_count", count, 5'd1);
    chk("st_after_stall_commit", commit_valid, 1'b1);
    chk("st_after_stall_val", commit_val, 32'h88);
    step();

    // 20 dispatch/commit pairs across the wrap point
    for (int i = 0; i < 20; i++) begin
      t = m_tail;
      idle(); disp(2'd0, 5'(i), 1'b0, 32'd0); step();
      idle(); set_wb(0, t, 32'(i * 3 + 1), 1'b0); step();
      idle(); #1;
      chk("wrap_commit_valid", commit_valid, 1'b1);
      chk("wrap_commit_tag", commit_tag, t);
      chk("wrap_commit_val", commit_val, 32'(i * 3 + 1));
      step();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 800; n++) begin
      int k;
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      disp_valid = ($urandom_range(0, 9) < 6);
      k = $urandom_range(0, 15);
      disp_kind = (k == 0) ? 2'd1 : (k < 3) ? 2'd2 : (k == 3) ? 2'd3 : 2'd0;
      disp_rd = 5'($urandom);
      disp_pred_taken = 1'($urandom);
      disp_alt_pc = $urandom;
      q1_tag = 4'($urandom);
      q2_tag = 4'($urandom);
      for (int p = 0; p < 2; p++) begin
        if ($urandom_range(0, 3) < ((n < 400) ? 1 : 3)) begin
          if (mq.size() > 0 && $urandom_range(0, 3) != 0)
            t = mq[$urandom_range(0, mq.size() - 1)].tag;
          else
            t = 4'($urandom);
          set_wb(p, t, $urandom, 1'($urandom));
        end
      end
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rob_multi_wb.md
ROB_MULTI_WB -- requirements
Module: rob_multi_wb

Interface
REQ-001 SHALL have parameter DEPTH, default 16, entry count; power of two, at least 4.
REQ-002 SHALL have parameter NUM_WB, default 2, number of writeback ports.
REQ-003 SHALL have parameter XLEN, default 32, data/PC width; IW = log2(DEPTH) is derived.
REQ-004 SHALL have one clock and an asynchronous, active-high reset: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-005 SHALL have rdy input 1, global enable; rdy=0 freezes all state.
REQ-006 SHALL have dispatch ports: disp_valid in 1; disp_ready out 1; disp_rd in 5; disp_kind in 2 (0 REG, 1 BRANCH, 2 STORE, 3 NOP); disp_pred_taken in 1; disp_alt_pc in XLEN (recovery PC); disp_tag out IW (= tail).
REQ-007 SHALL have operand lookup ports: q1_tag/q2_tag in IW; q1_ready/q2_ready out 1; q1_val/q2_val out XLEN.
REQ-008 SHALL have writeback ports: wb_valid in NUM_WB; wb_tag in NUM_WB*IW; wb_val in NUM_WB*XLEN; wb_taken in NUM_WB (branch outcome).
REQ-009 SHALL have commit ports: commit_valid out 1; commit_tag out IW; commit_rd out 5; commit_val out XLEN; commit_store out 1.
REQ-010 SHALL have recovery ports: flush out 1; flush_pc out XLEN.
REQ-011 SHALL have status ports: count out IW+1; empty out 1; full out 1.

Function
REQ-012 SHALL be a circular queue: head/tail pointers IW bits, wrapping DEPTH-1 -> 0; count tracks occupancy; full = (count==DEPTH); empty = (count==0).
REQ-013 SHALL drive disp_ready = !full && !flush; dispatch is accepted on a rising edge with rdy && disp_valid && disp_ready, writing a busy, not-ready entry at tail; tail+1.
REQ-014 SHALL accept at most one dispatch per cycle; when full, dispatch is refused even if a commit occurs in the same cycle.
REQ-015 SHALL on each wb_valid[i] with tag of a busy entry set ready and latch wb_val/wb_taken; writebacks to non-busy tags are ignored.
REQ-016 SHALL resolve two ports writing the same tag in one cycle by letting the lowest port index win.
REQ-017 SHALL make q ready=1 if the entry is ready, or if any wb port matches the tag this cycle (combinational bypass, lowest index wins); q_val is the stored or bypassed value, else 0.
REQ-018 SHALL drive commit_valid = rdy && !empty && head ready, combinational from registered state only, with no writeback bypass into commit.
REQ-019 SHALL commit on an edge with commit_valid: head+1, count-1; dispatch and commit in the same cycle leave count unchanged.
REQ-020 SHALL drive commit_rd = disp_rd for REG and 0 for BRANCH/STORE/NOP; commit_store = commit_valid && kind==STORE.
REQ-021 SHALL treat committing a BRANCH with taken != pred_taken as a mispredict: on that edge, clear all busy bits, set head=tail=0, count=0, drop any same-cycle dispatch, and register flush=1 with flush_pc=alt_pc.
REQ-022 SHALL hold flush high for exactly one cycle; the queue accepts dispatch again the cycle after flush falls.
REQ-023 SHALL leave flush=0 after a correctly predicted branch commit, which behaves like a normal commit.
REQ-024 SHALL make rdy=0 block dispatch, writeback and commit, with flush holding its value.

Reset
REQ-025 SHALL on rst=1 asynchronously clear head, tail, count, all busy/ready bits and flush; set flush_pc=0; drive commit_valid=0, commit_store=0, empty=1, full=0, disp_ready=1.
REQ-026 SHALL make reset mid-operation discard all entries without any commit or flush pulse.

Structure
REQ-027 SHALL place the disp_kind encodings and the XLEN default in shared package rob_pkg.
REQ-028 SHALL implement the per-tag priority writeback match, used by both the entry update and the operand bypass, as sub-module rob_wb_match.

Verification
REQ-029 SHALL cover: reset, then dispatch 16 REG entries -> full=1, disp_ready=0, count=16, tags 0..15.
REQ-030 SHALL cover: out-of-order wb to tags 2,0,1 -> commits in order 0,1,2, one per cycle, starting the cycle after tag 0 is ready.
REQ-031 SHALL cover: wb port0 and port1 both to tag 3, vals 0xA/0xB -> stored 0xA; q1_tag=3 in that cycle returns ready=1, val=0xA.
REQ-032 SHALL cover: BRANCH pred_taken=1, alt_pc=0x100, wb_taken=0 at head -> one-cycle flush=1, flush_pc=0x100, count=0, dispatch in that cycle dropped.
REQ-033 SHALL cover: head/tail wrap after 20 dispatch/commit pairs with DEPTH=16 -> commit order preserved, count never exceeds 16.
REQ-034 SHALL cover: STORE at head made ready -> commit_store=1 for one cycle, commit_rd=0; rdy=0 in the next cycle -> no further commit.
